memory_stage_unit: RTL and testbench

//  Memory-stage controller of the 5-stage ARM pipeline. It sits downstream of execute_unit and holds the instruction in MEM.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/memory_stage_unit_if.sv | 9 +
 rtl/mem_wait_timer.sv | 27 ++
 rtl/memory_stage_unit.sv | 99 +++++++++
 tb/tb_memory_stage_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and opcode helpers for the MEM stage.
package pipeline_pkg;

    localparam logic [6:0] OPCODE_NOP = 7'b0100000;

    typedef enum logic [0:0] {IDLE, WAIT} mem_state_t;

    function automatic logic is_mem(input logic [6:0] op);
        return (op[6:5] == 2'b11) || (op[6:3] == 4'b1000);
    endfunction

    function automatic logic is_ldr_lit(input logic [6:0] op);
        return op[6:2] == 5'b11100;
    endfunction

    function automatic logic is_branch(input logic [6:0] op);
        return op[6:4] == 3'b101;
    endfunction

endpackage

// File: rtl/memory_stage_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface memory_stage_unit_if;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output dmem_req, output dmem_we, input dmem_ack);
    modport slave  (input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles without an acknowledge and flags the timeout cycle.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    input  logic active,
    output logic timeout
);
    localparam int unsigned CW = $clog2(MAX_WAIT);

    logic [CW-1:0] cnt_q;

    assign timeout = active && (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/memory_stage_unit.sv
// MEM stage: holds the instruction leaving execute, runs the data-memory access
// with a bounded wait, and produces forwarding tags, writeback controls and stalls.
module memory_stage_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                opcode_in,
    input  logic [3:0]                rd_in,
    input  logic                      wr_rd_in,
    input  logic                      load_in,
    input  logic                      branch_in,
    input  logic [6:0]                opcode_ex,
    input  logic [3:0]                rn_ex,
    input  logic [3:0]                rm_ex,
    input  logic [3:0]                rs_ex,
    memory_stage_unit_if.master       dmem,
    output logic [3:0]                rd_memory,
    output logic [6:0]                opcode_memory,
    output logic                      stall_out,
    output logic                      en_wb,
    output logic [1:0]                sel_wb,
    output logic                      mem_fault
);
    mem_state_t state_q;
    logic [6:0] opcode_q;
    logic [3:0] rd_q;
    logic       wr_q;
    logic       load_q;
    logic       fault_q;

    logic wait_active;
    logic timeout;
    logic stall_wait;
    logic load_use;
    logic bubble;
    logic capture_mem;

    assign wait_active = (state_q == WAIT) && !dmem.dmem_ack;
    assign stall_wait  = wait_active && !timeout;

    assign load_use = load_q && wr_q && (opcode_ex != OPCODE_NOP) &&
                      ((rn_ex == rd_q) || (rm_ex == rd_q) || (rs_ex == rd_q));

    assign bubble      = load_use || branch_in;
    assign capture_mem = !bubble && is_mem(opcode_in);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!stall_wait),
        .inc     (stall_wait),
        .active  (wait_active),
        .timeout (timeout)
    );

    // Stage register and IDLE/WAIT control share one clocked block so that the
    // hold during a memory wait freezes both together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= OPCODE_NOP;
            rd_q     <= 4'd0;
            wr_q     <= 1'b0;
            load_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            fault_q <= timeout;
            if (!stall_wait) begin
                if (bubble) begin
                    opcode_q <= OPCODE_NOP;
                    wr_q     <= 1'b0;
                    load_q   <= 1'b0;
                end else begin
                    opcode_q <= opcode_in;
                    rd_q     <= rd_in;
                    wr_q     <= wr_rd_in;
                    load_q   <= load_in;
                end
                state_q <= capture_mem ? WAIT : IDLE;
            end
        end
    end

    assign dmem.dmem_req = (state_q == WAIT);
    assign dmem.dmem_we  = !load_q;

    // Loads and stores never feed the ALU forwarding path.
    assign opcode_memory = (wr_q && !load_q) ? opcode_q : OPCODE_NOP;
    assign rd_memory     = rd_q;
    assign en_wb         = wr_q && (opcode_q != OPCODE_NOP) && !stall_wait && !timeout;
    assign sel_wb        = load_q ? 2'b01 : 2'b00;
    assign stall_out     = stall_wait || load_use;
    assign mem_fault     = fault_q;
endmodule

// File: tb/tb_memory_stage_unit.sv
// Scenario bench for memory_stage_unit with writeback and memory-access scoreboards.
module tb_memory_stage_unit;
    localparam logic [6:0] NOP = 7'h20;
    localparam logic [6:0] ADD = 7'h08;
    localparam logic [6:0] LDR = 7'h60;
    localparam logic [6:0] STR = 7'h44;
    localparam int unsigned MAX_WAIT = 16;

    typedef struct {
        logic [3:0] rd;
        logic [1:0] sel;
        logic [6:0] fwd;
    } wb_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode_in;
    logic [3:0] rd_in;
    logic       wr_rd_in;
    logic       load_in;
    logic       branch_in;
    logic [6:0] opcode_ex;
    logic [3:0] rn_ex;
    logic [3:0] rm_ex;
    logic [3:0] rs_ex;
    logic [3:0] rd_memory;
    logic [6:0] opcode_memory;
    logic       stall_out;
    logic       en_wb;
    logic [1:0] sel_wb;
    logic       mem_fault;

    int n_tests = 0;
    int n_fail  = 0;

    wb_exp_t wb_q[$];
    logic    mem_q[$];

    memory_stage_unit_if dif ();

    memory_stage_unit #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode_in     (opcode_in),
        .rd_in         (rd_in),
        .wr_rd_in      (wr_rd_in),
        .load_in       (load_in),
        .branch_in     (branch_in),
        .opcode_ex     (opcode_ex),
        .rn_ex         (rn_ex),
        .rm_ex         (rm_ex),
        .rs_ex         (rs_ex),
        .dmem          (dif.master),
        .rd_memory     (rd_memory),
        .opcode_memory (opcode_memory),
        .stall_out     (stall_out),
        .en_wb         (en_wb),
        .sel_wb        (sel_wb),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    // Scoreboard side: pops an expectation whenever the DUT completes an access or writes back.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (dif.dmem_req && dif.dmem_ack) begin
                n_tests++;
                if (mem_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_sb: unexpected access, we=%0b", dif.dmem_we);
                end else begin
                    logic exp_we;
                    exp_we = mem_q.pop_front();
                    if (dif.dmem_we !== exp_we) begin
                        n_fail++;
                        $display("FAIL mem_sb_we: got %0b want %0b", dif.dmem_we, exp_we);
                    end
                end
            end
            if (en_wb) begin
                n_tests++;
                if (wb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_sb: unexpected writeback rd=%0d", rd_memory);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    if (rd_memory !== e.rd || sel_wb !== e.sel || opcode_memory !== e.fwd) begin
                        n_fail++;
                        $display("FAIL wb_sb: got rd=%0d sel=%b fwd=%h want rd=%0d sel=%b fwd=%h",
                                 rd_memory, sel_wb, opcode_memory, e.rd, e.sel, e.fwd);
                    end
                end
            end
        end
    end

    task automatic set_nop();
        opcode_in    = NOP;
        rd_in        = 4'd0;
        wr_rd_in     = 1'b0;
        load_in      = 1'b0;
        branch_in    = 1'b0;
        opcode_ex    = NOP;
        rn_ex        = 4'd0;
        rm_ex        = 4'd0;
        rs_ex        = 4'd0;
        dif.dmem_ack = 1'b0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [3:0] rd, input logic wr,
                         input logic ld);
        opcode_in = op;
        rd_in     = rd;
        wr_rd_in  = wr;
        load_in   = ld;
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (dif.dmem_req !== 1'b0 || stall_out !== 1'b0 || en_wb !== 1'b0 ||
            mem_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b stall=%b en_wb=%b fault=%b want 0000",
                     dif.dmem_req, stall_out, en_wb, mem_fault);
        end
        n_tests++;
        if (opcode_memory !== 7'h20 || rd_memory !== 4'd0 || sel_wb !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_tags: op=%h rd=%0d sel=%b want 20 0 00",
                     opcode_memory, rd_memory, sel_wb);
        end
    endtask

    task automatic test_alu();
        @(negedge clk);
        issue(ADD, 4'd3, 1'b1, 1'b0);
        wb_q.push_back('{rd: 4'd3, sel: 2'b00, fwd: ADD});
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (opcode_memory !== ADD || rd_memory !== 4'd3 || en_wb !== 1'b1 ||
            sel_wb !== 2'b00 || dif.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL alu: op=%h rd=%0d en=%b sel=%b req=%b want 08 3 1 00 0",
                     opcode_memory, rd_memory, en_wb, sel_wb, dif.dmem_req);
        end
        // A branch squashes the incoming instruction.
        @(negedge clk);
        issue(ADD, 4'd9, 1'b1, 1'b0);
        branch_in = 1'b1;
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (opcode_memory !== NOP || en_wb !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_flush: op=%h en=%b want 20 0", opcode_memory, en_wb);
        end
    endtask

    task automatic test_load_wait();
        @(negedge clk);
        issue(LDR, 4'd5, 1'b1, 1'b1);
        wb_q.push_back('{rd: 4'd5, sel: 2'b01, fwd: NOP});
        mem_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_nop();
            dif.dmem_ack = (i == 2);
            #1;
            n_tests++;
            if (dif.dmem_req !== 1'b1 || dif.dmem_we !== 1'b0 || opcode_memory !== NOP ||
                sel_wb !== 2'b01 || stall_out !== (i != 2)) begin
                n_fail++;
                $display("FAIL load_wait[%0d]: req=%b we=%b op=%h sel=%b stall=%b want 1 0 20 01 %b",
                         i, dif.dmem_req, dif.dmem_we, opcode_memory, sel_wb, stall_out, i != 2);
            end
        end
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (dif.dmem_req !== 1'b0 || stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: req=%b stall=%b want 0 0", dif.dmem_req, stall_out);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        issue(LDR, 4'd5, 1'b1, 1'b1);
        wb_q.push_back('{rd: 4'd5, sel: 2'b01, fwd: NOP});
        mem_q.push_back(1'b0);
        @(negedge clk);
        issue(ADD, 4'd7, 1'b1, 1'b0);
        opcode_ex    = ADD;
        rn_ex        = 4'd1;
        rm_ex        = 4'd5;
        rs_ex        = 4'd2;
        dif.dmem_ack = 1'b1;
        #1;
        n_tests++;
        if (stall_out !== 1'b1 || dif.dmem_req !== 1'b1 || en_wb !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_ack: stall=%b req=%b en=%b want 1 1 1",
                     stall_out, dif.dmem_req, en_wb);
        end
        // Execute was held, so the same ADD is presented again.
        @(negedge clk);
        set_nop();
        issue(ADD, 4'd7, 1'b1, 1'b0);
        wb_q.push_back('{rd: 4'd7, sel: 2'b00, fwd: ADD});
        #1;
        n_tests++;
        if (opcode_memory !== NOP || en_wb !== 1'b0 || stall_out !== 1'b0 ||
            dif.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_bubble: op=%h en=%b stall=%b req=%b want 20 0 0 0",
                     opcode_memory, en_wb, stall_out, dif.dmem_req);
        end
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (opcode_memory !== ADD || rd_memory !== 4'd7) begin
            n_fail++;
            $display("FAIL load_use_resume: op=%h rd=%0d want 08 7", opcode_memory, rd_memory);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        issue(STR, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            set_nop();
            #1;
            n_tests++;
            if (dif.dmem_req !== 1'b1 || dif.dmem_we !== 1'b1 || en_wb !== 1'b0 ||
                stall_out !== (i != MAX_WAIT - 1) || mem_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL str_wait[%0d]: req=%b we=%b en=%b stall=%b fault=%b",
                         i, dif.dmem_req, dif.dmem_we, en_wb, stall_out, mem_fault);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (mem_fault !== 1'b1 || dif.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: fault=%b req=%b want 1 0", mem_fault, dif.dmem_req);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (mem_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_pulse: fault=%b want 0", mem_fault);
        end
    endtask

    task automatic test_ack_at_limit();
        @(negedge clk);
        issue(LDR, 4'd6, 1'b1, 1'b1);
        wb_q.push_back('{rd: 4'd6, sel: 2'b01, fwd: NOP});
        mem_q.push_back(1'b0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            set_nop();
            dif.dmem_ack = (i == MAX_WAIT - 1);
        end
        #1;
        n_tests++;
        if (en_wb !== 1'b1 || stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_limit: en=%b stall=%b want 1 0", en_wb, stall_out);
        end
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (mem_fault !== 1'b0 || dif.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_limit_nofault: fault=%b req=%b want 0 0", mem_fault, dif.dmem_req);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(LDR, 4'd4, 1'b1, 1'b1);
        wb_q.push_back('{rd: 4'd4, sel: 2'b01, fwd: NOP});
        mem_q.push_back(1'b0);
        @(negedge clk);
        issue(STR, 4'd1, 1'b0, 1'b0);
        mem_q.push_back(1'b1);
        dif.dmem_ack = 1'b1;
        @(negedge clk);
        set_nop();
        dif.dmem_ack = 1'b1;
        #1;
        n_tests++;
        if (dif.dmem_req !== 1'b1 || dif.dmem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: req=%b we=%b want 1 1", dif.dmem_req, dif.dmem_we);
        end
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (dif.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: req=%b want 0", dif.dmem_req);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        issue(LDR, 4'd8, 1'b1, 1'b1);
        @(negedge clk);
        set_nop();
        #1;
        n_tests++;
        if (dif.dmem_req !== 1'b1 || stall_out !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_wait: req=%b stall=%b want 1 1", dif.dmem_req, stall_out);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (dif.dmem_req !== 1'b0 || stall_out !== 1'b0 || opcode_memory !== NOP) begin
            n_fail++;
            $display("FAIL async_reset: req=%b stall=%b op=%h want 0 0 20",
                     dif.dmem_req, stall_out, opcode_memory);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_nop();
        test_reset();
        test_alu();
        test_load_wait();
        test_load_use();
        test_timeout();
        test_ack_at_limit();
        test_back_to_back();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        n_tests++;
        if (wb_q.size() != 0 || mem_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: wb left=%0d mem left=%0d want 0 0", wb_q.size(), mem_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
